// File: rtl/cache_unit.sv
// cache_unit: 2-way set-associative, write-back / write-allocate byte cache
// in front of an internal 1 MiB backing store. Requests arrive as two beats
// on a shared tri-state command/data bus; responses return on the same bus.
module cache_unit #(
  parameter int SETS       = 32,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 32,
  parameter int MEM_BYTES  = 2**20,
  parameter int HIT_LAT    = 4,
  parameter int MEM_LAT    = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] address,
  inout  wire  [2:0]  c1,
  inout  wire  [15:0] d1,
  output logic [15:0] out1,
  output logic [15:0] out2
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int SET_W  = $clog2(SETS);
  localparam int ADDR_W = $clog2(MEM_BYTES);
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int LIDX_W = ADDR_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int LINES  = MEM_BYTES / LINE_BYTES;
  localparam int CNT_W  = $clog2(HIT_LAT + 2 * MEM_LAT + 1);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_RD8  = 3'd1,
    CMD_RD16 = 3'd2,
    CMD_RD32 = 3'd3,
    CMD_INV  = 3'd4,
    CMD_WR8  = 3'd5,
    CMD_WR16 = 3'd6,
    CMD_WR32 = 3'd7
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,    // waiting for beat 1
    S_BEAT2,   // beat 1 captured, expecting the matching beat 2
    S_LOOKUP,  // tag compare, pick the latency for this access
    S_WAIT,    // model hit/fill/writeback delay; commit on the last cycle
    S_RESP     // drive the response on c1/d1
  } state_t;

  // Storage
  logic [LINE_W-1:0]       r_mem  [LINES];
  logic [LINE_W-1:0]       r_data [WAYS][SETS];
  logic [TAG_W-1:0]        r_tag  [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WAYS-1:0] r_dirty;
  logic [SETS-1:0]         r_lru;      // index of the least-recently-used way

  // Request / control state
  state_t              r_state;
  state_t              w_state_nxt;
  cmd_t                r_cmd;
  logic [LIDX_W-1:0]   r_addr_hi;
  logic [OFF_W-1:0]    r_off;
  logic [15:0]         r_dhi;
  logic [15:0]         r_dlo;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_result;
  logic [15:0]         r_hits;
  logic [15:0]         r_misses;

  // Bus decode
  logic w_c1_active;
  logic w_beat1;
  logic w_beat2;

  // Lookup datapath
  logic [TAG_W-1:0]  w_tag;
  logic [SET_W-1:0]  w_set;
  logic [WAYS-1:0]   w_hit_vec;
  logic              w_hit;
  logic              w_way;
  logic              w_way_dirty;
  logic              w_wb;
  logic              w_is_read;
  logic              w_is_inv;
  logic              w_commit;
  logic [CNT_W-1:0]  w_wait_cycles;
  logic [LINE_W-1:0] w_line_old;
  logic [LINE_W-1:0] w_line_new;
  logic [LIDX_W-1:0] w_wb_line;
  logic [31:0]       w_wdata;
  logic [2:0]        w_nbytes;
  logic [31:0]       w_rd_result;

  // Output drive
  logic w_drive_c1;
  logic w_drive_d1;

  function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                           input logic [OFF_W-1:0]  idx);
    return line[{idx, 3'b000} +: 8];
  endfunction

  assign w_c1_active = (c1 != 3'd0);
  assign w_beat2     = (r_state == S_BEAT2) && (c1 == r_cmd);
  // A different nonzero command while waiting for beat 2 restarts the request.
  assign w_beat1     = ((r_state == S_IDLE) && w_c1_active) ||
                       ((r_state == S_BEAT2) && w_c1_active && (c1 != r_cmd));

  assign w_tag     = r_addr_hi[LIDX_W-1:SET_W];
  assign w_set     = r_addr_hi[SET_W-1:0];
  assign w_is_read = (r_cmd == CMD_RD8) || (r_cmd == CMD_RD16) || (r_cmd == CMD_RD32);
  assign w_is_inv  = (r_cmd == CMD_INV);

  // Tag compare across both ways of the addressed set.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_set][w] && (r_tag[w][w_set] == w_tag);
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_way       = w_hit ? w_hit_vec[1] : r_lru[w_set];
  assign w_way_dirty = r_valid[w_set][w_way] && r_dirty[w_set][w_way];
  // Write back the resident line when invalidating it, or the victim on a miss.
  assign w_wb        = w_is_inv ? (w_hit && w_way_dirty) : (!w_hit && w_way_dirty);
  assign w_wb_line   = {r_tag[w_way][w_set], w_set};
  assign w_line_old  = w_hit ? r_data[w_way][w_set] : r_mem[r_addr_hi];
  assign w_commit    = (r_state == S_WAIT) && (r_cnt == '0);

  // Two cycles of the total latency are spent in S_BEAT2->S_LOOKUP->S_WAIT.
  assign w_wait_cycles = CNT_W'(HIT_LAT - 2)
                       + ((!w_hit && !w_is_inv) ? CNT_W'(MEM_LAT) : '0)
                       + (w_wb ? CNT_W'(MEM_LAT) : '0);

  assign w_wdata  = (r_cmd == CMD_WR32) ? {r_dhi, r_dlo} : {16'h0000, r_dlo};
  assign w_nbytes = (r_cmd == CMD_WR8)  ? 3'd1 :
                    (r_cmd == CMD_WR16) ? 3'd2 : 3'd4;

  // Merge write bytes into the line little-endian, wrapping inside the line.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    logic [OFF_W-1:0] idx;
    idx        = '0;
    w_line_new = w_line_old;
    if (!w_is_read && !w_is_inv) begin
      for (int k = 0; k < 4; k++) begin
        idx = r_off + OFF_W'(k);
        if (k < int'(w_nbytes)) begin
          w_line_new[{idx, 3'b000} +: 8] = w_wdata[k*8 +: 8];
        end
      end
    end
  end

  // Gather up to four bytes from the line, wrapping inside the line.
  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = line_byte(w_line_old, r_off);
    b1 = line_byte(w_line_old, r_off + OFF_W'(1));
    b2 = line_byte(w_line_old, r_off + OFF_W'(2));
    b3 = line_byte(w_line_old, r_off + OFF_W'(3));
    case (r_cmd)
      CMD_RD8:  w_rd_result = {24'h000000, b0};
      CMD_RD16: w_rd_result = {16'h0000, b1, b0};
      default:  w_rd_result = {b3, b2, b1, b0};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and bus-drive decode.
  always_comb begin
    w_state_nxt = r_state;
    w_drive_c1  = 1'b0;
    w_drive_d1  = 1'b0;
    case (r_state)
      S_IDLE:   if (w_beat1) w_state_nxt = S_BEAT2;
      S_BEAT2: begin
        if (w_beat2)       w_state_nxt = S_LOOKUP;
        else if (!w_beat1) w_state_nxt = S_IDLE;
      end
      S_LOOKUP: w_state_nxt = S_WAIT;
      S_WAIT:   if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP: begin
        w_drive_c1 = 1'b1;
        w_drive_d1 = w_is_read;
        if (r_cnt == '0) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, latency counting, and tag-state / counter commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= CMD_NOP;
      r_addr_hi <= '0;
      r_off     <= '0;
      r_dhi     <= '0;
      r_dlo     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_lru     <= '0;
      r_hits    <= '0;
      r_misses  <= '0;
    end else begin
      if (w_beat1) begin
        r_cmd     <= cmd_t'(c1);
        r_addr_hi <= address;
        r_dhi     <= d1;
      end
      if (w_beat2) begin
        r_off <= address[OFF_W-1:0];
        r_dlo <= d1;
      end
      case (r_state)
        S_LOOKUP: r_cnt <= w_wait_cycles;
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_cnt    <= w_is_read ? CNT_W'(2) : '0;
            r_result <= w_rd_result;
            if (w_is_inv) begin
              if (w_hit) begin
                r_valid[w_set][w_way] <= 1'b0;
                r_dirty[w_set][w_way] <= 1'b0;
              end
            end else begin
              r_valid[w_set][w_way] <= 1'b1;
              r_dirty[w_set][w_way] <= w_is_read ? (w_hit && r_dirty[w_set][w_way]) : 1'b1;
              r_lru[w_set]          <= ~w_way;
              if (w_hit) begin
                if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
              end else begin
                if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
              end
            end
          end
        end
        S_RESP:   if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        default:  ;
      endcase
    end
  end

  // Line data, tags and backing store: written only at commit.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; valid bits gate their use and the backing store must survive rst_n.
    if (w_commit) begin
      if (w_wb) r_mem[w_wb_line] <= r_data[w_way][w_set];
      if (!w_is_inv) begin
        r_data[w_way][w_set] <= w_line_new;
        r_tag[w_way][w_set]  <= w_tag;
      end
    end
  end

  assign c1   = w_drive_c1 ? 3'd7 : 3'bzzz;
  assign d1   = w_drive_d1 ? ((r_cnt == '0) ? r_result[15:0] : r_result[31:16]) : 16'hzzzz;
  assign out1 = r_hits;
  assign out2 = r_misses;

endmodule

// File: tb/tb_cache_unit.sv
// tb_cache_unit: directed vectors for cache_unit with hand-computed latencies,
// read data and hit/miss counts.
module tb_cache_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] address;
  wire  [2:0]  c1;
  wire  [15:0] d1;
  logic [15:0] out1;
  logic [15:0] out2;

  logic        tb_oe;
  logic [2:0]  tb_c1;
  logic [15:0] tb_d1;

  int n_vec = 0;
  int n_bad = 0;

  assign c1 = tb_oe ? tb_c1 : 3'bzzz;
  assign d1 = tb_oe ? tb_d1 : 16'hzzzz;

  always #5 clk = ~clk;

  cache_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .c1      (c1),
    .d1      (d1),
    .out1    (out1),
    .out2    (out2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Two-beat request starting on the next falling edge, then release the bus.
  task automatic send(input logic [2:0] cmd, input logic [19:0] a,
                      input logic [15:0] hi, input logic [15:0] lo);
    @(negedge clk);
    tb_oe = 1'b1; tb_c1 = cmd; address = a[19:5]; tb_d1 = hi;
    @(negedge clk);
    address = {10'd0, a[4:0]}; tb_d1 = lo;
    @(negedge clk);
    tb_oe = 1'b0; tb_c1 = 3'd0; tb_d1 = 16'h0000; address = 15'd0;
  endtask

  // Count rising edges after beat 2 until c1 shows 7 (bounded).
  task automatic wait_resp(input string tag, input int exp_lat, output bit seen);
    int lat;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (c1 === 3'd7) seen = 1'b1;
    end
    check({tag, ".lat"}, seen ? lat : 999, exp_lat);
  endtask

  task automatic do_read(input string tag, input logic [2:0] cmd, input logic [19:0] a,
                         input int exp_lat, input logic [31:0] exp);
    bit seen;
    logic [15:0] w1, w2, w3;
    send(cmd, a, 16'h0000, 16'h0000);
    wait_resp(tag, exp_lat, seen);
    if (seen) begin
      w1 = d1;
      @(posedge clk); #1; w2 = d1;
      @(posedge clk); #1; w3 = d1;
      check({tag, ".data"}, {w1, w3}, exp);
      check({tag, ".hi2"}, {16'h0000, w2}, {16'h0000, exp[31:16]});
      @(posedge clk); #1;
      check({tag, ".len"}, {31'd0, c1 === 3'd7}, 32'd0);
    end
  endtask

  task automatic do_write(input string tag, input logic [2:0] cmd, input logic [19:0] a,
                          input logic [15:0] hi, input logic [15:0] lo, input int exp_lat);
    bit seen;
    send(cmd, a, hi, lo);
    wait_resp(tag, exp_lat, seen);
    if (seen) begin
      @(posedge clk); #1;
      check({tag, ".len"}, {31'd0, c1 === 3'd7}, 32'd0);
    end
  endtask

  initial begin
    int  cnt;
    bit  seen;
    tb_oe = 1'b0; tb_c1 = 3'd0; tb_d1 = 16'h0000; address = 15'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out1", {16'h0, out1}, 32'd0);
    check("rst.out2", {16'h0, out2}, 32'd0);
    check("rst.c1_idle", {31'd0, c1 === 3'd7}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Cold miss on a clean set: 4 + 20 cycles, zero data.
    do_read("rd_cold", 3'd3, 20'h00040, 24, 32'h00000000);
    check("rd_cold.out2", {16'h0, out2}, 32'd1);

    // Write-allocate miss, then hit.
    do_write("wr32", 3'd7, 20'h12344, 16'hDEAD, 16'hBEEF, 24);
    check("wr32.out2", {16'h0, out2}, 32'd2);
    do_read("rd_hit", 3'd3, 20'h12344, 4, 32'hDEADBEEF);
    check("rd_hit.out1", {16'h0, out1}, 32'd1);

    // Byte write merges little-endian into the line.
    do_write("wr8", 3'd5, 20'h12345, 16'h0000, 16'h0077, 4);
    do_read("rd_merge", 3'd3, 20'h12344, 4, 32'hDEAD77EF);
    do_read("rd8", 3'd1, 20'h12346, 4, 32'h000000AD);

    // 16-bit access at offset 31 wraps to offset 0 of the same line.
    do_write("wr16_wrap", 3'd6, 20'h1235F, 16'h0000, 16'hA55A, 4);
    do_read("rd_wrap0", 3'd3, 20'h12340, 4, 32'h000000A5);
    do_read("rd16_wrap", 3'd2, 20'h1235F, 4, 32'h0000A55A);
    check("wrap.out1", {16'h0, out1}, 32'd7);

    // Set 3: T0 written, T1 and T2 read; T2 evicts dirty T0 (20 extra).
    do_write("ev_wr_t0", 3'd7, 20'h00460, 16'hCAFE, 16'hF00D, 24);
    do_read("ev_rd_t1", 3'd3, 20'h00860, 24, 32'h00000000);
    do_read("ev_rd_t2", 3'd3, 20'h00C60, 44, 32'h00000000);
    do_read("ev_rd_t0", 3'd3, 20'h00460, 24, 32'hCAFEF00D);
    check("ev.out2", {16'h0, out2}, 32'd6);

    // Invalidate a dirty resident line (writeback), then re-read misses.
    do_write("inv_dirty", 3'd4, 20'h12344, 16'h0000, 16'h0000, 24);
    do_read("inv_reread", 3'd3, 20'h12344, 24, 32'hDEAD77EF);
    do_write("inv_absent", 3'd4, 20'h7FFE0, 16'h0000, 16'h0000, 4);
    check("inv.out1", {16'h0, out1}, 32'd7);
    check("inv.out2", {16'h0, out2}, 32'd7);

    // Lone beat followed by c1=0 must not produce a response.
    @(negedge clk);
    tb_oe = 1'b1; tb_c1 = 3'd3; address = 15'h0002; tb_d1 = 16'h0000;
    @(negedge clk);
    tb_c1 = 3'd0;
    @(negedge clk);
    tb_oe = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (c1 === 3'd7) cnt++;
    end
    check("abort.resp", cnt, 0);
    check("abort.out1", {16'h0, out1}, 32'd7);
    do_read("post_abort", 3'd3, 20'h00040, 4, 32'h00000000);
    check("post_abort.out1", {16'h0, out1}, 32'd8);

    // Reset during a miss wait: counters clear, line stays non-resident.
    send(3'd3, 20'h00080, 16'h0000, 16'h0000);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.c1", {31'd0, c1 === 3'd7}, 32'd0);
    check("rst_mid.out1", {16'h0, out1}, 32'd0);
    check("rst_mid.out2", {16'h0, out2}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_read("rst_mid.reread", 3'd3, 20'h00080, 24, 32'h00000000);
    check("rst_mid.out2b", {16'h0, out2}, 32'd1);

    // Backing store keeps written-back data across reset.
    do_read("rst_mem", 3'd3, 20'h12344, 24, 32'hDEAD77EF);

    // Reset during a response releases the bus without a clock edge.
    send(3'd3, 20'h00460, 16'h0000, 16'h0000);
    wait_resp("rst_resp", 24, seen);
    if (seen) begin
      check("rst_resp.d1", {16'h0, d1}, 32'h0000CAFE);
      #2 rst_n = 1'b0;
      #1;
      check("rst_resp.c1_rel", {31'd0, c1 === 3'd7}, 32'd0);
      check("rst_resp.d1_rel", {31'd0, d1 === 16'hCAFE}, 32'd0);
    end else begin
      rst_n = 1'b0;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    check("rst_resp.out2", {16'h0, out2}, 32'd0);
    do_read("rst_resp.reread", 3'd3, 20'h00460, 24, 32'hCAFEF00D);
    check("final.out2", {16'h0, out2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
